ram_sync_be: RTL and testbench

- Clocked, parametrised successor to the 512x8 combinational data RAM.
- Byte-addressed big-endian memory serving byte, halfword and word accesses (MAS encoding unchanged).
- Adds programmable wait states, a registered busy/done handshake, sign extension for byte and halfword loads (LDRSB/LDRSH), and fault reporting for misaligned, out-of-range and undefined-size accesses.
- Sits between the datapath memory-interface control and the data bus.

---
 rtl/ram_sync_be.sv | 208 ++++++++++++++++++++
 tb/tb_ram_sync_be.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_be.sv
// ram_sync_be: clocked byte-addressed big-endian data RAM with programmable
// wait states, a registered busy/done handshake, sign-extended sub-word loads
// and fault reporting for misaligned, out-of-range and undefined-size accesses.
module ram_sync_be #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  readWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           dataIn,
    input  logic [1:0]            MAS,
    input  logic                  signExt,
    output logic [31:0]           dataOut,
    output logic                  done,
    output logic                  busy,
    output logic                  fault
);

    // One extra bit so address + size - 1 never wraps.
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] MAS_BYTE = 2'b00;
    localparam logic [1:0] MAS_HALF = 2'b01;
    localparam logic [1:0] MAS_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             din_q, din_d;
    logic [1:0]              mas_q, mas_d;
    logic                    sx_q, sx_d;
    logic [31:0]             dout_q, dout_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    fault_q, fault_d;

    logic [7:0]              mem [DEPTH];

    logic [EXT_W-1:0]        addr_ext_c;
    logic [EXT_W-1:0]        last_c;
    logic [EXT_W-1:0]        size_m1_c;
    logic                    acc_fault_c;
    logic [EXT_W-1:0]        baddr_c [4];
    logic [IDX_W-1:0]        idx_c   [4];
    logic [7:0]              rbyte_c [4];
    logic [31:0]             rdata_c;
    logic                    wr_en_c;

    assign dataOut = dout_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign fault   = fault_q;

    // Fault decode on the latched request: bad size, misalignment, range overrun.
    always_comb begin
        addr_ext_c = {1'b0, addr_q};
        size_m1_c  = EXT_W'(3);
        case (mas_q)
            MAS_BYTE: size_m1_c = EXT_W'(0);
            MAS_HALF: size_m1_c = EXT_W'(1);
            default:  size_m1_c = EXT_W'(3);
        endcase
        last_c      = addr_ext_c + size_m1_c;
        acc_fault_c = 1'b0;
        if (mas_q == 2'b11)                            acc_fault_c = 1'b1;
        if ((mas_q == MAS_HALF) && addr_q[0])          acc_fault_c = 1'b1;
        if ((mas_q == MAS_WORD) && (addr_q[1:0] != 2'b00)) acc_fault_c = 1'b1;
        if (last_c >= EXT_W'(DEPTH))                   acc_fault_c = 1'b1;
    end

    // Fetch the four bytes starting at the latched address; out-of-range bytes read as 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            baddr_c[k] = addr_ext_c + EXT_W'(k);
            idx_c[k]   = IDX_W'(baddr_c[k]);
            rbyte_c[k] = (baddr_c[k] < EXT_W'(DEPTH)) ? mem[idx_c[k]] : 8'h00;
        end
    end

    // Assemble the right-justified, optionally sign-extended read result.
    always_comb begin
        rdata_c = 32'h0;
        case (mas_q)
            MAS_BYTE: rdata_c = {(sx_q ? {24{rbyte_c[0][7]}} : 24'h0), rbyte_c[0]};
            MAS_HALF: rdata_c = {(sx_q ? {16{rbyte_c[0][7]}} : 16'h0), rbyte_c[0], rbyte_c[1]};
            MAS_WORD: rdata_c = {rbyte_c[0], rbyte_c[1], rbyte_c[2], rbyte_c[3]};
            default:  rdata_c = 32'h0;
        endcase
    end

    assign wr_en_c = !reset && (state_q == S_ACCESS) && !rw_q && !acc_fault_c;

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            case (mas_q)
                MAS_BYTE: mem[idx_c[0]] <= din_q[7:0];
                MAS_HALF: begin
                    mem[idx_c[0]] <= din_q[15:8];
                    mem[idx_c[1]] <= din_q[7:0];
                end
                MAS_WORD: begin
                    mem[idx_c[0]] <= din_q[31:24];
                    mem[idx_c[1]] <= din_q[23:16];
                    mem[idx_c[2]] <= din_q[15:8];
                    mem[idx_c[3]] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    // Next-state and registered-output logic for the request handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mas_d   = mas_q;
        sx_d    = sx_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    rw_d   = readWrite;
                    addr_d = address;
                    din_d  = dataIn;
                    mas_d  = MAS;
                    sx_d   = signExt;
                    busy_d = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                fault_d = acc_fault_c;
                if (rw_q) begin
                    dout_d = acc_fault_c ? 32'h0 : rdata_c;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            mas_q   <= 2'b00;
            sx_q    <= 1'b0;
            dout_q  <= 32'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            mas_q   <= mas_d;
            sx_q    <= sx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_ram_sync_be.sv
// Bench for ram_sync_be: directed vector table, handshake/reset sequences and
// randomized traffic checked against a byte-array reference model.
module tb_ram_sync_be;

    localparam int AW    = 10;
    localparam int DEPTH = 512;
    localparam int WS    = 2;
    localparam int LAT   = WS + 2;   // negedges from accept edge to done cycle

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          readWrite;
    logic [AW-1:0] address;
    logic [31:0]   dataIn;
    logic [1:0]    MAS;
    logic          signExt;
    logic [31:0]   dataOut;
    logic          done;
    logic          busy;
    logic          fault;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [31:0] model_last;

    ram_sync_be #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .readWrite(readWrite),
        .address(address), .dataIn(dataIn), .MAS(MAS), .signExt(signExt),
        .dataOut(dataOut), .done(done), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        int          addr;
        logic [31:0] din;
        logic [1:0]  mas;
        logic        sx;
        logic [31:0] exp_dout;
        logic        exp_fault;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size, alignment and range rules on a plain byte array.
    function automatic void model_access(input logic rw, input int addr, input logic [31:0] din,
                                         input logic [1:0] mas, input logic sx,
                                         output logic [31:0] rd, output logic flt);
        int size;
        logic [31:0] v;
        size = (mas == 2'b00) ? 1 : (mas == 2'b01) ? 2 : 4;
        flt  = (mas == 2'b11) || ((addr % size) != 0) || (addr + size > DEPTH);
        rd   = model_last;
        if (!rw && !flt) begin
            for (int i = 0; i < size; i++)
                model_mem[addr + i] = 8'(din >> (8 * (size - 1 - i)));
        end
        if (rw) begin
            if (flt) begin
                rd = 32'h0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = (v << 8) | 32'(model_mem[addr + i]);
                if (sx && size < 4 && v[8 * size - 1])
                    v = v | ~((32'h1 << (8 * size)) - 32'h1);
                rd = v;
            end
            model_last = rd;
        end
    endfunction

    // Wait for the done pulse after an accepted request; lat counts negedges.
    task automatic wait_done(output logic [31:0] dout, output logic flt, output int lat);
        dout = 32'h0;
        flt  = 1'b0;
        lat  = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) begin
                dout = dataOut;
                flt  = fault;
                break;
            end
        end
    endtask

    task automatic do_req(input logic rw, input int addr, input logic [31:0] din,
                          input logic [1:0] mas, input logic sx,
                          output logic [31:0] dout, output logic flt, output int lat);
        @(negedge clk);
        enable    = 1'b1;
        readWrite = rw;
        address   = AW'(addr);
        dataIn    = din;
        MAS       = mas;
        signExt   = sx;
        @(posedge clk);
        #1;
        enable    = 1'b0;
        readWrite = 1'($urandom);
        address   = AW'($urandom);
        dataIn    = $urandom;
        MAS       = 2'($urandom);
        signExt   = 1'($urandom);
        wait_done(dout, flt, lat);
    endtask

    function automatic vec_t mk(input logic rw, input int addr, input logic [31:0] din,
                                input logic [1:0] mas, input logic sx,
                                input logic [31:0] ed, input logic ef);
        vec_t v;
        v.rw = rw; v.addr = addr; v.din = din; v.mas = mas; v.sx = sx;
        v.exp_dout = ed; v.exp_fault = ef;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [22];
        logic [31:0] d, ed;
        logic        f, ef;
        int          lat, ndone, a, r;
        logic        rw, sx;
        logic [1:0]  mas;
        logic [31:0] din;

        vecs[0]  = mk(1'b0, 'h010, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0);
        vecs[1]  = mk(1'b1, 'h010, 32'h0,        2'b00, 1'b0, 32'h000000DE, 1'b0);
        vecs[2]  = mk(1'b1, 'h011, 32'h0,        2'b00, 1'b0, 32'h000000AD, 1'b0);
        vecs[3]  = mk(1'b1, 'h012, 32'h0,        2'b00, 1'b0, 32'h000000BE, 1'b0);
        vecs[4]  = mk(1'b1, 'h013, 32'h0,        2'b00, 1'b0, 32'h000000EF, 1'b0);
        vecs[5]  = mk(1'b1, 'h012, 32'h0,        2'b01, 1'b0, 32'h0000BEEF, 1'b0);
        vecs[6]  = mk(1'b1, 'h012, 32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0);
        vecs[7]  = mk(1'b1, 'h011, 32'h0,        2'b00, 1'b1, 32'hFFFFFFAD, 1'b0);
        vecs[8]  = mk(1'b0, 'h011, 32'h11223344, 2'b10, 1'b0, 32'hFFFFFFAD, 1'b1);
        vecs[9]  = mk(1'b1, 'h013, 32'h0,        2'b01, 1'b0, 32'h00000000, 1'b1);
        vecs[10] = mk(1'b1, 'h010, 32'h0,        2'b11, 1'b0, 32'h00000000, 1'b1);
        vecs[11] = mk(1'b0, 'h010, 32'h00000000, 2'b11, 1'b0, 32'h00000000, 1'b1);
        vecs[12] = mk(1'b1, 'h010, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        vecs[13] = mk(1'b1, 'h1FE, 32'h0,        2'b10, 1'b0, 32'h00000000, 1'b1);
        vecs[14] = mk(1'b1, 'h1FC, 32'h0,        2'b10, 1'b0, 32'hA6A7A4A5, 1'b0);
        vecs[15] = mk(1'b1, 'h1FF, 32'h0,        2'b00, 1'b1, 32'hFFFFFFA5, 1'b0);
        vecs[16] = mk(1'b1, 'h200, 32'h0,        2'b00, 1'b0, 32'h00000000, 1'b1);
        vecs[17] = mk(1'b1, 'h1FF, 32'h0,        2'b01, 1'b0, 32'h00000000, 1'b1);
        vecs[18] = mk(1'b0, 'h014, 32'h000080C1, 2'b01, 1'b0, 32'h00000000, 1'b0);
        vecs[19] = mk(1'b1, 'h014, 32'h0,        2'b01, 1'b1, 32'hFFFF80C1, 1'b0);
        vecs[20] = mk(1'b1, 'h014, 32'h0,        2'b10, 1'b0, 32'h80C14C4D, 1'b0);
        vecs[21] = mk(1'b0, 'h3FF, 32'h000000AA, 2'b00, 1'b0, 32'h80C14C4D, 1'b1);

        reset = 1'b1; enable = 1'b0; readWrite = 1'b0; address = '0;
        dataIn = 32'h0; MAS = 2'b00; signExt = 1'b0;
        model_last = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dataOut", dataOut, 32'h0);
        check("reset done",    32'(done),  32'h0);
        check("reset busy",    32'(busy),  32'h0);
        check("reset fault",   32'(fault), 32'h0);
        reset = 1'b0;

        // Fill memory with byte pattern (addr ^ 0x5A).
        for (int i = 0; i < DEPTH; i += 4) begin
            din = {8'(i) ^ 8'h5A, 8'(i + 1) ^ 8'h5A, 8'(i + 2) ^ 8'h5A, 8'(i + 3) ^ 8'h5A};
            model_access(1'b0, i, din, 2'b10, 1'b0, ed, ef);
            do_req(1'b0, i, din, 2'b10, 1'b0, d, f, lat);
            if (i % 64 == 0) check($sformatf("init fault @%0h", i), 32'(f), 32'h0);
        end

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            model_access(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].mas, vecs[i].sx, ed, ef);
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].mas, vecs[i].sx, d, f, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d dataOut", i), d, vecs[i].exp_dout);
            check($sformatf("vec%0d fault", i), 32'(f), 32'(vecs[i].exp_fault));
        end

        // Handshake timing, enable while busy ignored.
        @(negedge clk);
        enable = 1'b1; readWrite = 1'b1; address = AW'('h010); MAS = 2'b10; signExt = 1'b0;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check("hs n1 busy", 32'(busy), 32'h1);
        check("hs n1 done", 32'(done), 32'h0);
        @(negedge clk);
        check("hs n2 busy", 32'(busy), 32'h1);
        check("hs n2 done", 32'(done), 32'h0);
        enable = 1'b1; readWrite = 1'b0; address = AW'('h010); dataIn = 32'h0; MAS = 2'b10;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check("hs n3 busy", 32'(busy), 32'h1);
        check("hs n3 done", 32'(done), 32'h0);
        @(negedge clk);
        check("hs n4 done",    32'(done),  32'h1);
        check("hs n4 busy",    32'(busy),  32'h0);
        check("hs n4 fault",   32'(fault), 32'h0);
        check("hs n4 dataOut", dataOut,    32'hDEADBEEF);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("hs no extra done", 32'(ndone), 32'h0);

        // Back-to-back: request presented during the done cycle.
        model_access(1'b1, 'h010, 32'h0, 2'b10, 1'b0, ed, ef);
        do_req(1'b1, 'h010, 32'h0, 2'b10, 1'b0, d, f, lat);
        check("b2b first dataOut", d, ed);
        enable = 1'b1; readWrite = 1'b1; address = AW'('h012); MAS = 2'b00; signExt = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        model_access(1'b1, 'h012, 32'h0, 2'b00, 1'b1, ed, ef);
        wait_done(d, f, lat);
        check("b2b latency", 32'(lat), 32'(LAT));
        check("b2b dataOut", d, 32'hFFFFFFBE);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        enable = 1'b1; readWrite = 1'b0; address = AW'('h020); dataIn = 32'h12345678; MAS = 2'b10;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst busy",    32'(busy),  32'h0);
        check("rst done",    32'(done),  32'h0);
        check("rst fault",   32'(fault), 32'h0);
        check("rst dataOut", dataOut,    32'h0);
        reset = 1'b0;
        model_last = 32'h0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst no done", 32'(ndone), 32'h0);
        model_access(1'b1, 'h020, 32'h0, 2'b10, 1'b0, ed, ef);
        do_req(1'b1, 'h020, 32'h0, 2'b10, 1'b0, d, f, lat);
        check("rst prior contents", d, 32'h7A7B7879);
        check("rst model agrees", d, ed);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            r   = int'($urandom_range(0, 9));
            rw  = 1'($urandom);
            mas = 2'($urandom_range(0, 3));
            sx  = 1'($urandom);
            din = $urandom;
            if (r == 0)      a = int'($urandom_range(500, 1023));
            else if (r < 4)  a = int'($urandom_range(0, 127)) * 4 + int'($urandom_range(0, 3));
            else             a = int'($urandom_range(0, 15)) * 4 + ((mas == 2'b00) ? int'($urandom_range(0, 3)) : 0);
            model_access(rw, a, din, mas, sx, ed, ef);
            do_req(rw, a, din, mas, sx, d, f, lat);
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(LAT));
            check($sformatf("rnd%0d dataOut a=%0h mas=%0d rw=%0d", i, a, mas, rw), d, ed);
            check($sformatf("rnd%0d fault", i), 32'(f), 32'(ef));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
